// File: rtl/mux4_rr_arbiter.sv
// Four-requester arbiter sharing one 4:1 mux and a single valid/ready output register.
// Round-robin or fixed-priority selection, with bounded burst locking.
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_lock,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       sel_q;
  logic [1:0]       grant;
  logic [CNT_W-1:0] burst_cnt;
  logic             lock_own;
  logic             any_valid;
  logic             load;
  logic             lock_hit;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  assign any_valid = |req_valid;
  assign load      = (state == EMPTY) | out_ready;
  // The lock-holder keeps the grant only while its burst budget lasts.
  assign lock_hit  = lock_own & req_valid[out_src] & (burst_cnt < CNT_W'(BURST_MAX));
  assign xfer      = rst_n & load & any_valid;

  // Grant selection: burst lock first, then round-robin scan or fixed priority.
  always_comb begin
    logic [1:0] idx;
    grant = 2'd0;
    idx   = 2'd0;
    if (lock_hit) begin
      grant = out_src;
    end else if (PRIO_MODE == 0) begin
      // Walk from the lowest-priority slot upward so the nearest valid slot after ptr wins.
      for (int i = 4; i >= 1; i--) begin
        idx = ptr + 2'(i);
        if (req_valid[idx]) grant = idx;
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (req_valid[i]) grant = 2'(i);
      end
    end
  end

  // Mux select and one-hot ready, both quiet while in reset.
  always_comb begin
    sel       = 2'd0;
    req_ready = 4'd0;
    if (rst_n) begin
      sel = any_valid ? grant : sel_q;
      if (load && any_valid) req_ready = 4'(4'b0001 << grant);
    end
  end

  // Shared 4:1 datapath mux.
  always_comb begin
    mux_data = req_data0;
    case (grant)
      2'd0: mux_data = req_data0;
      2'd1: mux_data = req_data1;
      2'd2: mux_data = req_data2;
      2'd3: mux_data = req_data3;
      default: mux_data = req_data0;
    endcase
  end

  // Output-register occupancy next state.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (any_valid) state_nxt = FULL;
      FULL:  if (out_ready && !any_valid) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Output register, scheduling pointer and burst tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      ptr       <= 2'd3;
      burst_cnt <= '0;
      lock_own  <= 1'b0;
      sel_q     <= 2'd0;
    end else begin
      sel_q     <= sel;
      out_valid <= (state_nxt == FULL);
      if (xfer) begin
        out_data <= mux_data;
        out_src  <= grant;
        ptr      <= grant;
        lock_own <= req_lock[grant];
        if ((grant == out_src) && lock_own) begin
          // Saturate at the budget; lock is ignored once it is reached.
          if (burst_cnt < CNT_W'(BURST_MAX)) burst_cnt <= burst_cnt + CNT_W'(1);
        end else begin
          burst_cnt <= CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: round-robin and fixed-priority instances share stimulus,
// each is compared against its own transaction-level reference model.
module tb_mux4_rr_arbiter;

  localparam int unsigned W  = 32;
  localparam int          BM = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_lock;
  logic [W-1:0] d0, d1, d2, d3;
  logic         out_ready;

  logic [3:0]   rdy0, rdy1;
  logic [1:0]   sel0, sel1, src0, src1;
  logic         ov0, ov1;
  logic [W-1:0] od0, od1;

  int errors = 0;
  int checks = 0;

  // Reference model state per instance (0 = round-robin, 1 = fixed priority).
  int           m_full[2], m_src[2], m_ptr[2], m_cnt[2], m_lock[2], m_sel[2];
  logic [W-1:0] m_data[2];

  mux4_rr_arbiter #(.WIDTH(W), .PRIO_MODE(0), .BURST_MAX(BM)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock),
    .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
    .req_ready(rdy0), .sel(sel0), .out_valid(ov0), .out_data(od0), .out_src(src0),
    .out_ready(out_ready)
  );

  mux4_rr_arbiter #(.WIDTH(W), .PRIO_MODE(1), .BURST_MAX(BM)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock),
    .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
    .req_ready(rdy1), .sel(sel1), .out_valid(ov1), .out_data(od1), .out_src(src1),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dat(int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  // Which requester the rules say wins now; -1 when nobody is valid.
  function automatic int pick(int k);
    if (req_valid == 4'd0) return -1;
    if (m_lock[k] != 0 && req_valid[m_src[k]] && m_cnt[k] < BM) return m_src[k];
    if (k == 0) begin
      for (int i = 1; i <= 4; i++) if (req_valid[(m_ptr[k] + i) % 4]) return (m_ptr[k] + i) % 4;
    end else begin
      for (int i = 0; i < 4; i++) if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 0; m_src[k] = 0; m_ptr[k] = 3; m_cnt[k] = 0;
      m_lock[k] = 0; m_sel[k] = 0; m_data[k] = '0;
    end
  endtask

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    int         g[2];
    bit         ld[2];
    logic [3:0] er;
    #1;
    for (int k = 0; k < 2; k++) begin
      g[k]  = pick(k);
      ld[k] = (m_full[k] == 0) || out_ready;
      er    = (ld[k] && g[k] >= 0) ? 4'(4'b0001 << g[k]) : 4'd0;
      chk(k == 0 ? "rr_ready" : "fp_ready", W'(k == 0 ? rdy0 : rdy1), W'(er));
      chk(k == 0 ? "rr_sel" : "fp_sel", W'(k == 0 ? sel0 : sel1),
          W'(g[k] >= 0 ? g[k] : m_sel[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (g[k] >= 0) m_sel[k] = g[k];
      if (ld[k] && g[k] >= 0) begin
        if (g[k] == m_src[k] && m_lock[k] != 0) m_cnt[k] = (m_cnt[k] < BM) ? m_cnt[k] + 1 : m_cnt[k];
        else m_cnt[k] = 1;
        m_data[k] = dat(g[k]);
        m_src[k]  = g[k];
        m_ptr[k]  = g[k];
        m_lock[k] = int'(req_lock[g[k]]);
        m_full[k] = 1;
      end else if (ld[k]) begin
        m_full[k] = 0;
      end
    end
    @(negedge clk);
    chk("rr_out_valid", W'(ov0), W'(m_full[0]));
    chk("rr_out_data", od0, m_data[0]);
    chk("rr_out_src", W'(src0), W'(m_src[0]));
    chk("fp_out_valid", W'(ov1), W'(m_full[1]));
    chk("fp_out_data", od1, m_data[1]);
    chk("fp_out_src", W'(src1), W'(m_src[1]));
  endtask

  task automatic check_reset_outputs();
    chk("rst_rr_ready", W'(rdy0), '0);
    chk("rst_fp_ready", W'(rdy1), '0);
    chk("rst_rr_valid", W'(ov0), '0);
    chk("rst_fp_valid", W'(ov1), '0);
    chk("rst_rr_data", od0, '0);
    chk("rst_rr_sel", W'(sel0), '0);
    chk("rst_fp_sel", W'(sel1), '0);
  endtask

  initial begin
    int rr_seq[5];
    int bu_seq[5];
    rr_seq = '{0, 1, 2, 3, 0};
    bu_seq = '{2, 2, 2, 2, 1};

    // Reset with every requester valid.
    rst_n = 1'b0; req_valid = 4'hF; req_lock = 4'h0; out_ready = 1'b1;
    d0 = 32'hA0; d1 = 32'hA1; d2 = 32'hA2; d3 = 32'hA3;
    mreset();
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Round-robin over four valid requesters, starting at 0 after reset.
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_seq_src", W'(src0), W'(rr_seq[i]));
      chk("rr_seq_data", od0, W'(32'hA0 + rr_seq[i]));
    end

    // Back-pressure: output and pointer frozen, then no source skipped.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_data", od0, 32'hA0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next_src", W'(src0), W'(1));

    // Burst: requester 2 locks, budget of four grants, then requester 1.
    req_lock = 4'b0100; req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("burst_src", W'(src0), W'(bu_seq[i]));
      req_valid = 4'b0110;
    end

    // Fixed priority: 1 wins over 3 until it drops.
    req_lock = 4'h0; req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fp_src_1", W'(src1), W'(1));
    end
    req_valid = 4'b1000;
    cycle();
    chk("fp_src_3", W'(src1), W'(3));

    // Drain: single word then idle.
    req_valid = 4'b0001;
    cycle();
    chk("drain_valid_hi", W'(ov0), W'(1));
    req_valid = 4'b0000;
    cycle();
    chk("drain_valid_lo", W'(ov0), W'(0));
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom);
      req_lock  = 4'($urandom);
      d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Asynchronous reset while the output register is full.
    req_valid = 4'hF; req_lock = 4'h0; out_ready = 1'b1;
    cycle();
    chk("pre_rst_valid", W'(ov0), W'(1));
    rst_n = 1'b0;
    #1;
    mreset();
    check_reset_outputs();
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    cycle();
    chk("post_rst_src", W'(src0), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
